// File: rtl/uart_pkg.sv
// uart_pkg: UART types and helpers shared by the transmit and receive sides.
// UART_TX_PARITY_EN adds the PARITY state to the transmit FSM.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } uart_tx_state_t;

    function automatic int clks_per_bit(
        input int clk_freq,
        input int baud_rate
    );
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake into the UART transmitter.
// Not affected by UART_TX_PARITY_EN.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH x 8 synchronous byte FIFO, reset flushes it.
// Not affected by UART_TX_PARITY_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [UART_DATA_BITS-1:0] wdata,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = count_q == CNT_FULL;
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8-N-1 UART transmitter, LSB first, idle high.
// Define UART_TX_PARITY_EN for 8-E-1 frames (even parity bit after data).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 6250000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  in_if,
    output logic      tx,
    output logic      busy
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(CPB);
    localparam int LW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    if (CPB < 2) begin : g_cpb_chk
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_tx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] head;
    logic tx_q, tx_d;
    logic busy_q, busy_d;
    logic rdy_q;
    logic push, pop, load, full, empty, bit_end;
    logic [LW:0] count, level_d;
`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`endif

    assign in_if.in_ready = rdy_q & ~full;
    assign push    = in_if.in_valid & in_if.in_ready;
    assign bit_end = cnt_q == CNT_LAST;
    assign tx      = tx_q;
    assign busy    = busy_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_if.in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        load    = 1'b0;
        pop     = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: load = ~empty;
            S_START: begin
                tx_d = 1'b0;
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                tx_d = shift_q[0];
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
`ifdef UART_TX_PARITY_EN
                    if (idx_q == IDX_LAST) state_d = S_PARITY;
`else
                    if (idx_q == IDX_LAST) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = par_q;
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                    load    = ~empty;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Shared pop path: IDLE start and gapless STOP-to-START chaining
        if (load) begin
            pop     = 1'b1;
            shift_d = head;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
        end
        level_d = count + (LW+1)'(push) - (LW+1)'(pop);
        busy_d  = (state_d != S_IDLE) || (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a byte scoreboard and line decoder.
// Define UART_TX_PARITY_EN to also check the 8-E-1 frame.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         t0;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;
    logic [7:0] sbq[$];
    frame_t     rxq[$];

    uart_tx_if in_if ();

    uart_tx #(
        .CLK_FREQ   (100000000),
        .BAUD_RATE  (6250000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in_if (in_if),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        int g;
        g = 0;
        in_if.in_data  = b;
        in_if.in_valid = 1'b1;
        while (in_if.in_ready !== 1'b1 && g < 1000) begin
            step();
            g++;
        end
        chk("push_wait", g < 1000, 1);
        sbq.push_back(b);
        step();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int g;
        g = 0;
        while (rxq.size() < n && g < budget) begin
            step();
            g++;
        end
        chk("rx_wait", rxq.size() >= n, 1);
    endtask

    task automatic check_frame(input string tag, output int t0);
        frame_t f;
        logic [7:0] e;
        logic ok;
        t0 = 0;
        ok = rxq.size() > 0 && sbq.size() > 0;
        chk({tag, "_avail"}, ok, 1);
        if (!ok) return;
        f = rxq.pop_front();
        e = sbq.pop_front();
        chk({tag, "_data"}, f.data, e);
        chk({tag, "_stop"}, f.stop, 1);
`ifdef UART_TX_PARITY_EN
        chk({tag, "_par"}, f.par, ^e);
`endif
        t0 = f.t0;
    endtask

    // Line decoder: finds the start edge, samples each bit mid-cell
    initial begin : mon
        int t0, off;
        logic [7:0] sh;
        logic par;
        bit act;
        frame_t f;
        act = 0;
        t0  = 0;
        sh  = '0;
        par = 1'b0;
        forever begin
            @(negedge clk);
            off = cyc - t0;
            if (rst) begin
                act = 0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1;
                    t0  = cyc;
                end
            end else if (off == FRAME - CPB / 2) begin
                f.data = sh;
                f.par  = par;
                f.stop = tx;
                f.t0   = t0;
                rxq.push_back(f);
                act = 0;
            end else if (off >= CPB + CPB / 2 && off % CPB == CPB / 2) begin
                if (off < 9 * CPB) sh = {tx, sh[7:1]};
                else par = tx;
            end
        end
    end

    initial begin : main
        int n, t0, t1, t2, a1, acc, lows;
        logic took;
        in_if.in_data  = '0;
        in_if.in_valid = 1'b0;

        step(3);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_if.in_ready, 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", in_if.in_ready, 1);
        chk("idle_tx", tx, 1);

        push(8'h55);
        in_if.in_valid = 1'b0;
        n = cyc;
        step();
        chk("t1_tx_n1", tx, 1);
        chk("t1_busy", busy, 1);
        wait_rx(1, 2 * FRAME);
        check_frame("t1", t0);
        chk("t1_latency", t0, n + 2);
        while (cyc < n + FRAME) step();
        chk("t1_busy_last", busy, 1);
        step();
        chk("t1_busy_fall", busy, 0);
        chk("t1_tx_idle", tx, 1);

        push(8'h00);
        push(8'hFF);
        push(8'hA5);
        in_if.in_valid = 1'b0;
        wait_rx(3, 4 * FRAME);
        check_frame("b2b0", t0);
        check_frame("b2b1", t1);
        check_frame("b2b2", t2);
        chk("b2b_gap01", t1 - t0, FRAME);
        chk("b2b_gap12", t2 - t1, FRAME);

        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        chk("idle_before_fill", busy, 0);
        acc = 0;
        a1  = 0;
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'h30;
        for (int g = 0; g < 40; g++) begin
            took = in_if.in_ready;
            if (took) begin
                if (acc == 0) a1 = cyc + 1;
                sbq.push_back(in_if.in_data);
                acc++;
            end
            step();
            if (took) in_if.in_data = in_if.in_data + 8'd1;
        end
        chk("fill_accepts", acc, 5);
        chk("fill_ready_low", in_if.in_ready, 0);
        n = 0;
        while (in_if.in_ready !== 1'b1 && n < 2 * FRAME) begin
            step();
            n++;
        end
        chk("full_pop_ready", cyc, a1 + 1 + FRAME);
        sbq.push_back(in_if.in_data);
        step();
        in_if.in_valid = 1'b0;
        chk("refill_ready_low", in_if.in_ready, 0);
        wait_rx(6, 7 * FRAME);
        check_frame("fill0", t0);
        for (int k = 1; k < 6; k++) begin
            check_frame($sformatf("fill%0d", k), t1);
            chk($sformatf("fill_gap%0d", k), t1 - t0, FRAME);
            t0 = t1;
        end

        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        push(8'h3C);
        n = cyc;
        push(8'hC3);
        push(8'h5A);
        in_if.in_valid = 1'b0;
        while (cyc < n + 2 + 50) step();
        rst = 1'b1;
        step();
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_if.in_ready, 0);
        sbq.delete();
        rst = 1'b0;
        step();
        chk("post_rst_ready", in_if.in_ready, 1);
        lows = 0;
        repeat (3 * FRAME) begin
            step();
            if (tx !== 1'b1) lows++;
        end
        chk("post_rst_tx_quiet", lows, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_no_frame", rxq.size(), 0);

`ifdef UART_TX_PARITY_EN
        push(8'h07);
        push(8'h03);
        in_if.in_valid = 1'b0;
        wait_rx(2, 3 * FRAME);
        if (rxq.size() >= 2) begin
            chk("par_07", rxq[0].par, 1);
            chk("par_03", rxq[1].par, 0);
        end
        check_frame("par0", t0);
        check_frame("par1", t1);
        chk("par_frame_len", t1 - t0, 176);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the debug/console path, the transmit counterpart of the receive-side monitor on the same serial line. Accepts bytes over a valid/ready handshake into a small FIFO and serialises them as 8-N-1 frames, LSB first, on `tx`. Synthesizable; also drives the TX stimulus for serial-line loopback benches.

## Interface
- `CLK_FREQ`, 100000000: input clock frequency in Hz.
- `BAUD_RATE`, 6250000: line rate in bit/s; `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE` (integer divide, must be ≥ 2, elaboration error otherwise).
- `FIFO_DEPTH`, 4: byte FIFO entries, power of two, ≥ 2.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: byte to transmit.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: FIFO not full; byte accepted on an edge where `in_valid && in_ready`.
- `tx` output 1: serial line, idle high, registered.
- `busy` output 1: frame in progress or FIFO non-empty.

## Operation
- Reset values: `tx`=1, `busy`=0, `in_ready`=1 from the first edge after `rst` deasserts (0 while `rst`=1); FIFO empty, FSM in IDLE, counters 0.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: if FIFO non-empty, pop head into shift register, bit index=0, go START; else hold `tx`=1.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `tx`=shift[0]; after `CLKS_PER_BIT` cycles shift right, index+1; after index 7 go PARITY (if enabled) else STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles; at end, if FIFO non-empty pop and go directly to START (no idle gap), else IDLE.
- Bit counter width `$clog2(CLKS_PER_BIT)`; counts 0..CLKS_PER_BIT-1, wraps to 0 on bit boundary.
- FIFO full: `in_ready`=0, `in_valid` ignored, no overwrite. Simultaneous push and pop when full: pop frees a slot but `in_ready` reflects the pre-edge state; push is not accepted that cycle.
- Simultaneous push into empty FIFO while IDLE: byte is popped on the following edge.
- `rst` mid-frame: frame abandoned, FIFO flushed, `tx`=1 on the edge `rst` is sampled.

## Timing
- Handshake edge N → FIFO non-empty at N+1 → FSM pops at edge N+1, `tx` low from edge N+2.
- Every bit exactly `CLKS_PER_BIT` cycles; frame 10×`CLKS_PER_BIT` cycles (11× with parity).
- Back-to-back frames: stop bit of frame k immediately followed by start bit of frame k+1.
- `busy` falls on the edge the FSM enters IDLE with FIFO empty.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted after DATA, `tx` = XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles; frame 8-E-1.
- Undefined: no PARITY state, no parity logic; frame 8-N-1.

## Structure
- Package `uart_pkg`: FSM state enum (`uart_tx_state_t`), `UART_DATA_BITS`=8, helper function computing `CLKS_PER_BIT`; shared with the receive side.
- Sub-module `uart_tx_fifo`: synchronous FIFO (`FIFO_DEPTH`×8), push/pop/full/empty, sync active-high reset flush.

## Test plan
- CLKS_PER_BIT=16, push 0x55 at edge N → `tx` low from N+2 for 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, stop 1; frame 160 cycles; `busy` low after.
- Push 0x00, 0xFF, 0xA5 back-to-back with `in_valid` held → three contiguous 160-cycle frames, no idle high between stop and next start.
- Hold `in_valid` with line stalled, FIFO_DEPTH=4 → `in_ready` drops after 5 accepts (4 in FIFO + 1 in shifter), no byte lost or duplicated.
- Assert `rst` at cycle 50 of a 0x3C frame → `tx`=1, `busy`=0, `in_ready`=0 next edge; pre-queued bytes never transmitted.
- With `UART_TX_PARITY_EN`, push 0x07 → parity bit 1, frame 176 cycles; push 0x03 → parity bit 0.
- Loopback `tx` into the receive monitor at 6.25 Mbaud, send "Hi\n" → log contains exactly "Hi\n".
